// File: rtl/softmax_ctrl_pkg.sv
// softmax_ctrl_pkg: shared states, length modes and defaults for the softmax share arbiter
package softmax_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam logic [1:0] LM_16 = 2'd0;
  localparam logic [1:0] LM_32 = 2'd1;
  localparam logic [1:0] LM_64 = 2'd2;
  localparam int N_DEFAULT = 64;
  function automatic logic [1:0] len_mode(input logic [7:0] len);
    return (len == 8'd0 || len > 8'd64) ? LM_64 : (len <= 8'd16) ? LM_16 : (len <= 8'd32) ? LM_32 : LM_64;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin grant, first requester after last_id wins
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_id,
  output logic            any,
  output logic [IW-1:0]   g
);
  // scan from farthest to nearest so the nearest requester after last_id overrides
  always_comb begin
    any = |req;
    g = '0;
    for (int i = NREQ; i >= 1; i--)
      if (req[(int'(last_id) + i) % NREQ]) g = IW'((int'(last_id) + i) % NREQ);
  end
endmodule

// File: rtl/softmax_share_arbiter.sv
// softmax_share_arbiter: shares one softmax engine among NREQ requesters with timeout abort
module softmax_share_arbiter
  import softmax_ctrl_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int NREQ = 4,
  parameter int TIMEOUT = 1024,
  parameter int IW = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*8-1:0]   req_len,
  input  logic [NREQ*N*16-1:0] req_x_flat,
  output logic [NREQ-1:0]     req_ack,
  output logic                sm_valid_in,
  output logic [1:0]          sm_length_mode,
  output logic [N*16-1:0]     sm_in_x_flat,
  input  logic                sm_valid_out,
  input  logic [N*16-1:0]     sm_prob_flat,
  output logic                rsp_valid,
  output logic [IW-1:0]       rsp_id,
  output logic                rsp_timeout,
  output logic [N*16-1:0]     rsp_prob_flat,
  output logic                busy
);
  localparam logic [15:0] CNT_MAX = 16'(TIMEOUT - 1);
  state_t state;
  logic [IW-1:0] last_id;
  logic [15:0] cnt;
  logic any;
  logic [IW-1:0] g;
  rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req(req_valid),
    .last_id(last_id),
    .any(any),
    .g(g)
  );
  // control FSM; pulses default low, engine result wins over a same-cycle timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_id <= IW'(NREQ - 1);
      cnt <= '0;
      req_ack <= '0;
      sm_valid_in <= 1'b0;
      sm_length_mode <= '0;
      sm_in_x_flat <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_timeout <= 1'b0;
      rsp_prob_flat <= '0;
      busy <= 1'b0;
    end else begin
      req_ack <= '0;
      sm_valid_in <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (any) begin
          req_ack <= NREQ'(1) << g;
          sm_in_x_flat <= req_x_flat[N*16*int'(g) +: N*16];
          sm_length_mode <= len_mode(req_len[8*int'(g) +: 8]);
          rsp_id <= g;
          last_id <= g;
          busy <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          sm_valid_in <= 1'b1;
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= (cnt == CNT_MAX) ? cnt : cnt + 16'd1;
          if (sm_valid_out) begin
            rsp_valid <= 1'b1;
            rsp_timeout <= 1'b0;
            rsp_prob_flat <= sm_prob_flat;
            busy <= 1'b0;
            state <= IDLE;
          end else if (cnt == CNT_MAX) begin
            rsp_valid <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_prob_flat <= '0;
            busy <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_softmax_share_arbiter.sv
// tb_softmax_share_arbiter: directed table and sequence checks for softmax_share_arbiter
module tb_softmax_share_arbiter;
  import softmax_ctrl_pkg::*;
  localparam int N = 64;
  localparam int NREQ = 4;
  localparam int TIMEOUT = 16;
  localparam int IW = 2;
  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*8-1:0] req_len;
  logic [NREQ*N*16-1:0] req_x_flat;
  logic [NREQ-1:0] req_ack;
  logic sm_valid_in;
  logic [1:0] sm_length_mode;
  logic [N*16-1:0] sm_in_x_flat;
  logic sm_valid_out;
  logic [N*16-1:0] sm_prob_flat;
  logic rsp_valid;
  logic [IW-1:0] rsp_id;
  logic rsp_timeout;
  logic [N*16-1:0] rsp_prob_flat;
  logic busy;
  int nvec = 0;
  int nmis = 0;
  typedef struct {
    logic [3:0] rv;
    logic [7:0] len;
    logic [3:0] ack;
    logic [1:0] mode;
  } vec_t;
  vec_t tbl[9];

  always #5 clk = ~clk;

  softmax_share_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT), .IW(IW)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_len(req_len),
    .req_x_flat(req_x_flat),
    .req_ack(req_ack),
    .sm_valid_in(sm_valid_in),
    .sm_length_mode(sm_length_mode),
    .sm_in_x_flat(sm_in_x_flat),
    .sm_valid_out(sm_valid_out),
    .sm_prob_flat(sm_prob_flat),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_timeout(rsp_timeout),
    .rsp_prob_flat(rsp_prob_flat),
    .busy(busy)
  );

  function automatic logic [N*16-1:0] xpat(input int k);
    logic [N*16-1:0] r;
    for (int j = 0; j < N; j++) r[16*j +: 16] = 16'(k * 4096 + j * 3 + 1);
    return r;
  endfunction

  function automatic logic [N*16-1:0] ppat(input int s);
    logic [N*16-1:0] r;
    for (int j = 0; j < N; j++) r[16*j +: 16] = 16'(s * 977 + j * 13 + 5);
    return r;
  endfunction

  function automatic int oh(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_len(input logic [7:0] len);
    for (int k = 0; k < NREQ; k++) req_len[8*k +: 8] = len;
  endtask

  task automatic wait_ack(input logic [3:0] exp);
    for (int k = 0; k < 20; k++) begin
      tick;
      if (req_ack != '0) break;
    end
    check("req_ack", req_ack, exp);
  endtask

  task automatic wait_svi;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (sm_valid_in) break;
    end
    check("sm_valid_in", sm_valid_in, 1);
  endtask

  task automatic respond(input int l, input logic [N*16-1:0] d);
    repeat (l) tick;
    sm_valid_out = 1'b1;
    sm_prob_flat = d;
    tick;
    sm_valid_out = 1'b0;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_timeout", rsp_timeout, 0);
    check("rsp_prob", rsp_prob_flat == d, 1);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " req_ack"}, req_ack, 0);
    check({tag, " sm_valid_in"}, sm_valid_in, 0);
    check({tag, " mode"}, sm_length_mode, 0);
    check({tag, " x_zero"}, sm_in_x_flat == '0, 1);
    check({tag, " rsp_valid"}, rsp_valid, 0);
    check({tag, " rsp_id"}, rsp_id, 0);
    check({tag, " rsp_timeout"}, rsp_timeout, 0);
    check({tag, " prob_zero"}, rsp_prob_flat == '0, 1);
    check({tag, " busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1;
    req_valid = '0;
    req_len = '0;
    sm_valid_out = 1'b0;
    sm_prob_flat = '0;
    for (int i = 0; i < NREQ; i++) req_x_flat[N*16*i +: N*16] = xpat(i);
    tbl[0] = '{4'b1111, 8'd16, 4'b0001, LM_16};
    tbl[1] = '{4'b1111, 8'd17, 4'b0010, LM_32};
    tbl[2] = '{4'b1111, 8'd32, 4'b0100, LM_32};
    tbl[3] = '{4'b1111, 8'd33, 4'b1000, LM_64};
    tbl[4] = '{4'b1111, 8'd64, 4'b0001, LM_64};
    tbl[5] = '{4'b1010, 8'd0, 4'b0010, LM_64};
    tbl[6] = '{4'b1010, 8'd200, 4'b1000, LM_64};
    tbl[7] = '{4'b1010, 8'd1, 4'b0010, LM_16};
    tbl[8] = '{4'b1010, 8'd48, 4'b1000, LM_64};
    rst = 1'b1;
    tick;
    tick;
    check_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      req_valid = tbl[i].rv;
      set_len(tbl[i].len);
      wait_ack(tbl[i].ack);
      wait_svi;
      check("tbl mode", sm_length_mode, tbl[i].mode);
      check("tbl x", sm_in_x_flat == xpat(oh(tbl[i].ack)), 1);
      respond(1, ppat(i + 1));
      check("tbl rsp_id", rsp_id, oh(tbl[i].ack));
    end
    req_valid = '0;
    do_reset;
    req_valid = 4'b0100;
    set_len(8'd16);
    tick;
    check("s1 ack", req_ack, 4'b0100);
    check("s1 busy", busy, 1);
    req_valid = '0;
    tick;
    check("s1 svi", sm_valid_in, 1);
    check("s1 mode", sm_length_mode, LM_16);
    check("s1 x", sm_in_x_flat == xpat(2), 1);
    check("s1 ack low", req_ack, 0);
    respond(5, ppat(20));
    check("s1 rsp_id", rsp_id, 2);
    tick;
    check("s1 rsp pulse", rsp_valid, 0);
    check("s1 prob held", rsp_prob_flat == ppat(20), 1);
    check("s1 busy low", busy, 0);
    req_valid = 4'b0001;
    set_len(8'd64);
    tick;
    check("to ack", req_ack, 4'b0001);
    req_valid = '0;
    tick;
    check("to svi", sm_valid_in, 1);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      tick;
      k = i;
      if (rsp_valid) break;
    end
    check("to latency", k, 16);
    check("to rsp_valid", rsp_valid, 1);
    check("to timeout", rsp_timeout, 1);
    check("to prob zero", rsp_prob_flat == '0, 1);
    check("to rsp_id", rsp_id, 0);
    req_valid = 4'b0010;
    set_len(8'd20);
    tick;
    check("co ack", req_ack, 4'b0010);
    req_valid = '0;
    tick;
    check("co svi", sm_valid_in, 1);
    repeat (15) tick;
    check("co no early rsp", rsp_valid, 0);
    sm_valid_out = 1'b1;
    sm_prob_flat = ppat(30);
    tick;
    sm_valid_out = 1'b0;
    check("co rsp_valid", rsp_valid, 1);
    check("co timeout", rsp_timeout, 0);
    check("co prob", rsp_prob_flat == ppat(30), 1);
    check("co rsp_id", rsp_id, 1);
    tick;
    sm_valid_out = 1'b1;
    tick;
    sm_valid_out = 1'b0;
    check("idle svo rsp", rsp_valid, 0);
    check("idle svo busy", busy, 0);
    tick;
    check("idle svo rsp2", rsp_valid, 0);
    req_valid = 4'b1000;
    set_len(8'd40);
    tick;
    check("rw ack", req_ack, 4'b1000);
    req_valid = '0;
    tick;
    check("rw svi", sm_valid_in, 1);
    tick;
    tick;
    check("rw busy", busy, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_zero("rst wait");
    tick;
    sm_valid_out = 1'b1;
    sm_prob_flat = ppat(35);
    tick;
    sm_valid_out = 1'b0;
    check("rw late svo", rsp_valid, 0);
    tick;
    check("rw late svo2", rsp_valid, 0);
    req_valid = 4'b0001;
    set_len(8'd10);
    tick;
    check("hold ack", req_ack, 4'b0001);
    tick;
    check("hold no ack", req_ack, 0);
    check("hold svi", sm_valid_in, 1);
    req_valid = '0;
    tick;
    check("hold no ack2", req_ack, 0);
    respond(3, ppat(40));
    check("hold rsp_id", rsp_id, 0);
    tick;
    check("hold ack idle", req_ack, 0);
    check("hold busy", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
